// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: FSM encoding and digit constants.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adder.sv
// One BCD digit of addition with decimal carry. The 'bad' output (invalid
// operand digit) exists only when BCD_INPUT_CHECK_EN is defined.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
`ifdef BCD_INPUT_CHECK_EN
  output logic               bad,
`endif
  output logic               co
);

  logic [DIGIT_W:0] t;

  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
    if (t > {1'b0, MAX_DIGIT}) begin
      s  = DIGIT_W'(t - 5'd10);
      co = 1'b1;
    end else begin
      s  = t[DIGIT_W-1:0];
      co = 1'b0;
    end
  end

`ifdef BCD_INPUT_CHECK_EN
  assign bad = (a > MAX_DIGIT) || (b > MAX_DIGIT);
`endif

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one digit per clock, LSB first, Done pulse on completion.
// Define BCD_INPUT_CHECK_EN to flag invalid operand digits on Err and zero the result.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [DIGIT_W*NDIG-1:0] A,
  input  logic [DIGIT_W*NDIG-1:0] B,
  input  logic                    Cin,
  input  logic                    Start,
  output logic                    Busy,
  output logic                    Done,
  output logic [DIGIT_W*NDIG-1:0] S,
  output logic                    Cout,
  output logic                    Err
);

  localparam int W     = DIGIT_W * NDIG;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, s_q, s_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIGIT_W-1:0] dig_s;
  logic             dig_co;
`ifdef BCD_INPUT_CHECK_EN
  logic             err_q, err_d;
  logic             dig_bad;
`endif

  // Operands shift right each digit, so the adder always sees the current digit at the bottom.
  bcd_digit_adder u_digit (
    .a   (a_q[DIGIT_W-1:0]),
    .b   (b_q[DIGIT_W-1:0]),
    .ci  (carry_q),
    .s   (dig_s),
`ifdef BCD_INPUT_CHECK_EN
    .bad (dig_bad),
`endif
    .co  (dig_co)
  );

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef BCD_INPUT_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          s_d     = '0;
`ifdef BCD_INPUT_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        s_d[int'(idx_q)*DIGIT_W +: DIGIT_W] = dig_s;
        carry_d = dig_co;
        a_d     = a_q >> DIGIT_W;
        b_d     = b_q >> DIGIT_W;
`ifdef BCD_INPUT_CHECK_EN
        err_d   = err_q | dig_bad;
`endif
        if (idx_q == LAST_IDX) begin
          cout_d  = dig_co;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
`ifdef BCD_INPUT_CHECK_EN
        if (err_q) begin
          s_d    = '0;
          cout_d = 1'b0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only; all flops reset asynchronously.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BCD_INPUT_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;
`ifdef BCD_INPUT_CHECK_EN
  assign Err  = err_q;
`else
  assign Err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder with NDIG=4.
module tb_bcd_serial_adder;

  logic        Clock;
  logic        Reset;
  logic [15:0] A, B, S;
  logic        Cin, Start, Busy, Done, Cout, Err;

  int checks;
  int errors;
  int lat;
  int pulses;
  logic [15:0] s_at_done;

  bcd_serial_adder #(.NDIG(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Start (Start),
    .Busy  (Busy),
    .Done  (Done),
    .S     (S),
    .Cout  (Cout),
    .Err   (Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Launch an addition from IDLE (or from the Done cycle) and wait for Done.
  task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci);
    A = a; B = b; Cin = ci; Start = 1'b1;
    tick();
    Start = 1'b0;
    check({tag, "_busy_start"}, 32'(Busy), 32'd1);
    lat = 0;
    while (!Done && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_busy_at_done"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    #12;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_s",    32'(S),    32'd0);
    check("rst_cout", 32'(Cout), 32'd0);
    check("rst_err",  32'(Err),  32'd0);
    Reset = 1'b0;
    tick();

    run_add("add1234", 16'h1234, 16'h4321, 1'b0);
    check("add1234_s",    32'(S),    32'h5555);
    check("add1234_cout", 32'(Cout), 32'd0);
    check("add1234_err",  32'(Err),  32'd0);
    tick();
    check("add1234_done_one_cycle", 32'(Done), 32'd0);

    // Second Start two cycles after the first must be ignored.
    A = 16'h1234; B = 16'h4321; Cin = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    A = 16'h1111; B = 16'h1111; Start = 1'b1;
    tick();
    Start = 1'b0;
    pulses = 0;
    s_at_done = '0;
    for (int i = 0; i < 15; i++) begin
      if (Done) begin
        pulses++;
        s_at_done = S;
      end
      tick();
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_s", 32'(s_at_done), 32'h5555);

    run_add("ripple", 16'h9999, 16'h0001, 1'b0);
    check("ripple_s",    32'(S),    32'h0000);
    check("ripple_cout", 32'(Cout), 32'd1);

    // Launched from the Done cycle above: latency check proves acceptance.
    run_add("max", 16'h9999, 16'h9999, 1'b1);
    check("max_s",    32'(S),    32'h9999);
    check("max_cout", 32'(Cout), 32'd1);
    A = 16'h0000; B = 16'h0000; Cin = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("hold_s",    32'(S),    32'h9999);
    check("hold_cout", 32'(Cout), 32'd1);
    check("hold_done", 32'(Done), 32'd0);

    // Reset two cycles into ADD.
    A = 16'h1234; B = 16'h4321; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_s",    32'(S),    32'd0);
    check("midrst_cout", 32'(Cout), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (Done) pulses++;
    end
    check("midrst_no_done", pulses, 0);

    run_add("five", 16'h0005, 16'h0005, 1'b0);
    check("five_s",    32'(S),    32'h0010);
    check("five_cout", 32'(Cout), 32'd0);

    run_add("baddig", 16'h12A4, 16'h0001, 1'b0);
`ifdef BCD_INPUT_CHECK_EN
    check("baddig_err",  32'(Err),  32'd1);
    check("baddig_s",    32'(S),    32'h0000);
    check("baddig_cout", 32'(Cout), 32'd0);
`else
    check("baddig_err",  32'(Err),  32'd0);
    check("baddig_s",    32'(S),    32'h1305);
    check("baddig_cout", 32'(Cout), 32'd0);
`endif

    run_add("after_bad", 16'h0005, 16'h0005, 1'b0);
    check("after_bad_err", 32'(Err), 32'd0);
    check("after_bad_s",   32'(S),   32'h0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL have parameter NDIG, default 4, giving the number of BCD digits per operand (1..8).
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port A, input, 4*NDIG bits: BCD operand A, digit 0 in bits [3:0].
REQ-005 SHALL have port B, input, 4*NDIG bits: BCD operand B, same packing as A.
REQ-006 SHALL have port Cin, input, 1 bit: carry-in to digit 0.
REQ-007 SHALL have port Start, input, 1 bit: request to begin an addition.
REQ-008 SHALL have port Busy, output, 1 bit: an addition is in progress.
REQ-009 SHALL have port Done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-010 SHALL have port S, output, 4*NDIG bits: BCD sum, packed the same as A; it feeds the downstream digit-split/7-segment stage.
REQ-011 SHALL have port Cout, output, 1 bit: carry out of the most-significant digit.
REQ-012 SHALL have port Err, output, 1 bit: an operand contained an invalid digit (see REQ-024).

Function
REQ-013 SHALL implement an FSM with the states IDLE, ADD and DONE.
REQ-014 SHALL, in IDLE with Start=1, latch A, B and Cin into internal registers, clear the digit index, clear S and Err, and enter ADD on the next edge.
REQ-015 SHALL, in ADD, process one digit per cycle, starting at digit 0 (LSB):
- t = a_i + b_i + c (5-bit value, range 0..19);
- if t > 9: digit = t - 10 and c = 1;
- otherwise: digit = t and c = 0;
- the digit is written into S[4i+3:4i].
REQ-016 SHALL leave ADD for DONE after digit NDIG-1 is written, and register Cout from the final carry at that point.
REQ-017 SHALL, in DONE, assert Done for exactly one cycle and then return to IDLE.
REQ-018 SHALL give fixed latency: Start sampled at edge 0 means Done=1 during the cycle following edge NDIG+1.
REQ-019 SHALL drive Busy=1 in the ADD and DONE states, and Busy=0 in IDLE.
REQ-020 SHALL ignore Start while Busy=1; no restart and no queuing.
REQ-021 SHALL hold S, Cout and Err stable from Done until the next accepted Start.
REQ-022 SHALL allow Start in the same cycle as Done, to be accepted on the next cycle (in IDLE).

Reset
REQ-023 SHALL, on Reset=1 at any time including mid-ADD, asynchronously force:
- state = IDLE;
- S = 0, Cout = 0, Done = 0, Busy = 0, Err = 0;
- digit index = 0.
Operation SHALL resume on the first edge after Reset deasserts.

Configuration
REQ-024 SHALL, with macro BCD_INPUT_CHECK_EN defined:
- check each digit pair as it is processed;
- if any a_i or b_i > 9, set Err=1, continue to completion, and at DONE force S=0 and Cout=0.
REQ-025 SHALL, without BCD_INPUT_CHECK_EN:
- tie Err to 0;
- build no digit-check logic;
- apply the REQ-015 arithmetic to invalid digits unchanged (result undefined as BCD).

Structure
REQ-026 SHALL place the following in shared package bcd_pkg:
- FSM state encoding;
- digit width constant (4);
- maximum digit constant (9).
REQ-027 SHALL contain one combinational sub-module bcd_digit_adder with inputs a[3:0], b[3:0], ci and outputs s[3:0], co, plus bad when BCD_INPUT_CHECK_EN is defined.
REQ-028 SHALL keep the FSM, operand registers and digit index in the top module only.

Verification (NDIG=4)
REQ-029 SHALL verify that A=1234, B=4321, Cin=0, Start pulse gives S=5555, Cout=0, and Done exactly 5 cycles after the Start edge.
REQ-030 SHALL verify that A=9999, B=0001, Cin=0 gives S=0000 and Cout=1 (carry ripples through all digits).
REQ-031 SHALL verify that A=9999, B=9999, Cin=1 gives S=9999 and Cout=1, and that S holds after Done until the next Start.
REQ-032 SHALL verify that a second Start with A=1111, B=1111, pulsed 2 cycles after the first Start (A=1234, B=4321), is ignored: the result is S=5555 and only one Done pulse occurs.
REQ-033 SHALL verify that Reset pulsed 2 cycles into ADD immediately gives Busy=0, S=0, Cout=0 and no Done, and that a following Start with A=0005, B=0005 gives S=0010.
REQ-034 SHALL verify, with BCD_INPUT_CHECK_EN defined, that A=0x12A4, B=0x0001 gives Err=1, S=0000 and Cout=0 at Done; without the macro, Err SHALL remain 0.
